// File: rtl/gam_pattern_feeder_if.sv
// Learning-handshake bundle between a pattern loader, the pattern feeder and
// the downstream Memory_Layer.
//
// Ports carried:
//   load_valid/load_ready/load_x/load_c/load_last : loader write channel
//   ready_wait                                     : READY(1)/WAIT(0) from Memory_Layer
//   x/c                                            : presented training pair
//   learning_done/presented_count/stall/err_zero_class : feeder status
//
// The slave modport is the feeder's view; master is the loader/consumer side.
interface gam_pattern_feeder_if #(
    parameter int NODE_W  = 32,
    parameter int CLASS_W = 32
);
    logic               load_valid;
    logic               load_ready;
    logic [NODE_W-1:0]  load_x;
    logic [CLASS_W-1:0] load_c;
    logic               load_last;
    logic               ready_wait;
    logic [NODE_W-1:0]  x;
    logic [CLASS_W-1:0] c;
    logic               learning_done;
    logic [15:0]        presented_count;
    logic               stall;
    logic               err_zero_class;

    modport slave (
        input  load_valid, load_x, load_c, load_last, ready_wait,
        output load_ready, x, c, learning_done, presented_count, stall,
               err_zero_class
    );

    modport master (
        output load_valid, load_x, load_c, load_last, ready_wait,
        input  load_ready, x, c, learning_done, presented_count, stall,
               err_zero_class
    );
endinterface

// File: rtl/gam_pattern_feeder.sv
// Pattern feeder for the Memory_Layer learning handshake. Buffers (node, class,
// last) triples from a loader in a FIFO and presents one pair on x/c per
// WAIT->READY edge of ready_wait. Raises learning_done once the take following
// the last pair has been seen.
//
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset; flushes FIFO and all outputs
//   bus      : gam_pattern_feeder_if.slave (loader channel, take input,
//              presented pair and status outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented yet since reset
// PRESENT | a pair is on x/c, waiting for the next take
// STALL   | a take arrived with the FIFO empty; pop on first entry
// DONE    | last pair consumed; outputs frozen until reset
module gam_pattern_feeder #(
    parameter int NODE_W  = 32,
    parameter int CLASS_W = 32,
    parameter int DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gam_pattern_feeder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = NODE_W + CLASS_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_STALL,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [EW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               full, empty;
    logic               wr_en, zero_wr;
    logic               pop;
    logic               take;
    logic               ready_wait_q;

    logic [EW-1:0]      head;
    logic [NODE_W-1:0]  head_x;
    logic [CLASS_W-1:0] head_c;
    logic               head_last;

    logic [NODE_W-1:0]  x_q;
    logic [CLASS_W-1:0] c_q;
    logic               last_q;
    logic [15:0]        count_q;
    logic               stall_q;
    logic               done_q;
    logic               err_q;

    // ---------------- FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign bus.load_ready = !full;

    // A zero class is acknowledged on the handshake but never stored.
    assign wr_en   = bus.load_valid && !full && (bus.load_c != '0);
    assign zero_wr = bus.load_valid && !full && (bus.load_c == '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {bus.load_last, bus.load_c, bus.load_x};
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_x    = head[NODE_W-1:0];
    assign head_c    = head[NODE_W +: CLASS_W];
    assign head_last = head[EW-1];

    // ---------------- take detection ----------------
    // ready_wait_q resets to WAIT so a READY held through reset release
    // still yields exactly one take.
    assign take = bus.ready_wait && !ready_wait_q;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = S_PRESENT;
                    end else begin
                        state_nx = S_STALL;
                    end
                end
            end
            S_PRESENT: begin
                if (take) begin
                    if (last_q) begin
                        state_nx = S_DONE;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = S_STALL;
                    end
                end
            end
            S_STALL: begin
                // Takes seen here are dropped; only data arrival matters.
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_PRESENT;
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ready_wait_q <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            x_q          <= '0;
            c_q          <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
            stall_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nx;
            ready_wait_q <= bus.ready_wait;
            stall_q      <= (state_nx == S_STALL);
            done_q       <= (state_nx == S_DONE);
            err_q        <= err_q | zero_wr;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                x_q    <= head_x;
                c_q    <= head_c;
                last_q <= head_last;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign bus.x               = x_q;
    assign bus.c               = c_q;
    assign bus.learning_done   = done_q;
    assign bus.presented_count = count_q;
    assign bus.stall           = stall_q;
    assign bus.err_zero_class  = err_q;

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Directed bench for gam_pattern_feeder: learning sequence, DONE hold,
// asynchronous reset flush, stall path, zero-class drop, full-FIFO collision,
// and READY held across reset release.
module tb_gam_pattern_feeder;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] vec [8];

    gam_pattern_feeder_if #(.NODE_W(32), .CLASS_W(32)) bus ();

    gam_pattern_feeder #(.NODE_W(32), .CLASS_W(32), .DEPTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [31:0] wx, input logic [31:0] wc,
                             input logic wl);
        bus.load_valid = 1'b1;
        bus.load_x     = wx;
        bus.load_c     = wc;
        bus.load_last  = wl;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic take();
        bus.ready_wait = 1'b1;
        tick();
        bus.ready_wait = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec = '{32'h0003, 32'h0400, 32'h070005, 32'h0101,
                32'h0c0b0a09, 32'h0604, 32'h060002, 32'h0202};
        reset_n        = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_x     = '0;
        bus.load_c     = '0;
        bus.load_last  = 1'b0;
        bus.ready_wait = 1'b0;

        // reset values
        #3;
        chk("rst_x", bus.x, 0);
        chk("rst_c", bus.c, 0);
        chk("rst_done", bus.learning_done, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_count", bus.presented_count, 0);
        chk("rst_err", bus.err_zero_class, 0);
        chk("rst_load_ready", bus.load_ready, 1);
        #9;
        reset_n = 1'b1;
        tick();

        // learning sequence of 8 pairs, 9 takes
        for (int i = 0; i < 8; i++) write_one(vec[i], 32'd1, (i == 7));
        for (int i = 0; i < 8; i++) begin
            take();
            chk($sformatf("seq_x%0d", i), bus.x, vec[i]);
            chk($sformatf("seq_c%0d", i), bus.c, 1);
        end
        chk("seq_done_before_last_take", bus.learning_done, 0);
        take();
        chk("seq_done", bus.learning_done, 1);
        chk("seq_count", bus.presented_count, 8);
        chk("seq_x_held", bus.x, 32'h0202);

        // DONE ignores takes, still accepts writes
        write_one(32'h5555, 32'd3, 1'b0);
        take();
        take();
        chk("done_x_held", bus.x, 32'h0202);
        chk("done_c_held", bus.c, 1);
        chk("done_count_held", bus.presented_count, 8);
        chk("done_still_done", bus.learning_done, 1);
        chk("done_load_ready", bus.load_ready, 1);

        // asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_x", bus.x, 0);
        chk("arst_c", bus.c, 0);
        chk("arst_done", bus.learning_done, 0);
        chk("arst_count", bus.presented_count, 0);
        chk("arst_load_ready", bus.load_ready, 1);
        #3;
        reset_n = 1'b1;
        tick();

        // take with empty FIFO (also proves the DONE-era write was flushed)
        take();
        chk("stall_set", bus.stall, 1);
        chk("stall_x_zero", bus.x, 0);
        bus.load_valid = 1'b1;
        bus.load_x     = 32'h0003;
        bus.load_c     = 32'd1;
        tick();
        bus.load_valid = 1'b0;
        chk("stall_no_bypass_x", bus.x, 0);
        chk("stall_no_bypass_stall", bus.stall, 1);
        tick();
        chk("stall_x", bus.x, 32'h0003);
        chk("stall_clear", bus.stall, 0);
        chk("stall_count", bus.presented_count, 1);

        // zero class dropped, sticky error
        write_one(32'hdead, 32'd0, 1'b0);
        chk("zero_err", bus.err_zero_class, 1);
        chk("zero_load_ready", bus.load_ready, 1);
        write_one(32'h0400, 32'd2, 1'b0);
        take();
        chk("zero_next_x", bus.x, 32'h0400);
        chk("zero_next_c", bus.c, 2);
        chk("zero_count", bus.presented_count, 2);
        take();
        chk("zero_fifo_empty", bus.stall, 1);
        chk("zero_err_sticky", bus.err_zero_class, 1);

        // full FIFO with simultaneous take and write
        apply_reset();
        for (int i = 0; i < 16; i++) write_one(32'h100 + 32'(i), 32'(i + 1), 1'b0);
        chk("full_load_ready", bus.load_ready, 0);
        bus.ready_wait = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_x     = 32'hbad;
        bus.load_c     = 32'd5;
        #1;
        chk("full_refuse", bus.load_ready, 0);
        tick();
        bus.ready_wait = 1'b0;
        bus.load_valid = 1'b0;
        chk("full_pop_x", bus.x, 32'h100);
        chk("full_pop_c", bus.c, 1);
        chk("full_ready_back", bus.load_ready, 1);
        tick();
        for (int i = 1; i < 16; i++) begin
            take();
            chk($sformatf("drain_x%0d", i), bus.x, 32'h100 + 32'(i));
        end
        take();
        chk("drain_refused_write_absent", bus.stall, 1);
        chk("drain_count", bus.presented_count, 16);

        // READY held across reset release
        @(negedge clk);
        reset_n        = 1'b0;
        bus.ready_wait = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("hold_stall", bus.stall, 1);
        write_one(32'haaaa, 32'd7, 1'b0);
        write_one(32'hbbbb, 32'd8, 1'b0);
        tick();
        tick();
        chk("hold_x", bus.x, 32'haaaa);
        chk("hold_count_one", bus.presented_count, 1);
        chk("hold_no_stall", bus.stall, 0);
        bus.ready_wait = 1'b0;
        tick();
        bus.ready_wait = 1'b1;
        tick();
        chk("hold_retake_x", bus.x, 32'hbbbb);
        chk("hold_retake_count", bus.presented_count, 2);
        bus.ready_wait = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
